// File: rtl/conv_scheduler.sv
// conv_scheduler: walks every output position of the result map and, per
// position, every kernel tap. Drives anchor/tap indices to conv_buffer,
// acc_clr/acc_en to the MAC, and presents each finished dot product on a
// valid/ready result port.
//
// Ports:
//   clk_en         clock, rising edge
//   rst_n          synchronous reset, active-high
//   conv_on        start request (sampled in IDLE)
//   anchor_l/_c    window origin (out_row*stride, out_col*stride), 32 bit
//   buf_l/_c       tap row/column within the kernel, 4 bit
//   acc_clr        clear MAC accumulator (LOAD)
//   acc_en         accumulate current tap (SCAN)
//   result_valid   MAC sum for (result_l, result_c) is ready
//   result_ready   downstream accepts the result
//   result_l/_c    output row/column index, 16 bit
//   busy           high in every state except IDLE
//   done           one-cycle pulse after the last result is accepted
//
// Optional feature: define CONV_SCHED_ABORT_EN to let conv_on=0 abort a run
// from LOAD/SCAN/DRAIN/EMIT back to IDLE (no done pulse).
module conv_scheduler #(
  parameter int unsigned weight_width  = 2,
  parameter int unsigned weight_height = 2,
  parameter int unsigned img_width     = 4,
  parameter int unsigned img_height    = 4,
  parameter int unsigned padding       = 0,
  parameter int unsigned stride        = 1,
  parameter int unsigned result_width  = (img_width - weight_width + 2 * padding) / stride + 1,
  parameter int unsigned result_height = (img_height - weight_height + 2 * padding) / stride + 1,
  parameter int unsigned mac_latency   = 1
) (
  input  logic        clk_en,
  input  logic        rst_n,
  input  logic        conv_on,
  output logic [31:0] anchor_l,
  output logic [31:0] anchor_c,
  output logic [3:0]  buf_l,
  output logic [3:0]  buf_c,
  output logic        acc_clr,
  output logic        acc_en,
  output logic        result_valid,
  input  logic        result_ready,
  output logic [15:0] result_l,
  output logic [15:0] result_c,
  output logic        busy,
  output logic        done
);

  if (weight_width > 16 || weight_height > 16 || weight_width == 0 || weight_height == 0) begin : g_bad_kernel
    $error("conv_scheduler: kernel dimensions must be 1..16");
  end
  if (mac_latency > 15) begin : g_bad_latency
    $error("conv_scheduler: mac_latency must be 0..15");
  end

  localparam logic [3:0]  TAP_L_LAST = 4'(weight_height - 1);
  localparam logic [3:0]  TAP_C_LAST = 4'(weight_width - 1);
  localparam logic [3:0]  DRAIN_INIT = 4'(mac_latency - 1);
  localparam logic [15:0] ROW_LAST   = 16'(result_height - 1);
  localparam logic [15:0] COL_LAST   = 16'(result_width - 1);
  localparam bit          HAS_DRAIN  = (mac_latency > 0);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SCAN,
    DRAIN,
    EMIT,
    DONE
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [15:0] out_row;
  logic [15:0] out_col;
  logic [3:0]  tap_l;
  logic [3:0]  tap_c;
  logic [3:0]  drain_cnt;
  logic        last_tap;
  logic        last_pos;
  logic        handshake;
  logic [31:0] anchor_row;
  logic [31:0] anchor_col;

  assign last_tap   = (tap_l == TAP_L_LAST) && (tap_c == TAP_C_LAST);
  assign last_pos   = (out_row == ROW_LAST) && (out_col == COL_LAST);
  assign handshake  = (state == EMIT) && result_ready;
  assign anchor_row = 32'(out_row) * 32'(stride);
  assign anchor_col = 32'(out_col) * 32'(stride);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (conv_on) state_nx = LOAD;
      LOAD:  state_nx = SCAN;
      SCAN:  if (last_tap) state_nx = HAS_DRAIN ? DRAIN : EMIT;
      DRAIN: if (drain_cnt == '0) state_nx = EMIT;
      EMIT:  if (result_ready) state_nx = last_pos ? DONE : LOAD;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
`ifdef CONV_SCHED_ABORT_EN
    if (!conv_on && (state inside {LOAD, SCAN, DRAIN, EMIT})) state_nx = IDLE;
`endif
  end

  always_comb begin
    anchor_l     = '0;
    anchor_c     = '0;
    buf_l        = '0;
    buf_c        = '0;
    acc_clr      = 1'b0;
    acc_en       = 1'b0;
    result_valid = 1'b0;
    result_l     = '0;
    result_c     = '0;
    busy         = (state != IDLE);
    done         = 1'b0;
    unique case (state)
      LOAD: begin
        acc_clr  = 1'b1;
        anchor_l = anchor_row;
        anchor_c = anchor_col;
      end
      SCAN: begin
        acc_en   = 1'b1;
        anchor_l = anchor_row;
        anchor_c = anchor_col;
        buf_l    = tap_l;
        buf_c    = tap_c;
      end
      DRAIN: begin
        anchor_l = anchor_row;
        anchor_c = anchor_col;
        buf_l    = tap_l;
        buf_c    = tap_c;
      end
      EMIT: begin
        result_valid = 1'b1;
        result_l     = out_row;
        result_c     = out_col;
        anchor_l     = anchor_row;
        anchor_c     = anchor_col;
        buf_l        = tap_l;
        buf_c        = tap_c;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_en) begin
    if (rst_n) begin
      state     <= IDLE;
      out_row   <= '0;
      out_col   <= '0;
      tap_l     <= '0;
      tap_c     <= '0;
      drain_cnt <= '0;
    end else begin
      state <= state_nx;

      if (state == IDLE && conv_on) begin
        out_row <= '0;
        out_col <= '0;
      end else if (handshake && state_nx != IDLE) begin
        if (out_col == COL_LAST) begin
          out_col <= '0;
          out_row <= out_row + 16'd1;
        end else begin
          out_col <= out_col + 16'd1;
        end
      end

      // Taps are cleared on the way into LOAD so they stay at the last tap
      // throughout DRAIN and EMIT.
      if (state_nx == LOAD) begin
        tap_l <= '0;
        tap_c <= '0;
      end else if (state == SCAN && !last_tap) begin
        if (tap_c == TAP_C_LAST) begin
          tap_c <= '0;
          tap_l <= tap_l + 4'd1;
        end else begin
          tap_c <= tap_c + 4'd1;
        end
      end

      if (state == SCAN && last_tap) begin
        drain_cnt <= DRAIN_INIT;
      end else if (state == DRAIN && drain_cnt != '0) begin
        drain_cnt <= drain_cnt - 4'd1;
      end
    end
  end

endmodule
